conv_encoder_bs: RTL and testbench

Byte-serial, rate-1/3, tail-biting convolutional encoder (LTE generators 133/171/165 octal, constraint length 7) for the convolutional-encoder datapath. It pulls one message byte per cycle from an upstream byte FIFO. Each byte is encoded into three 8-bit parity sub-blocks, which are buffered in internal output FIFOs until the downstream rate-matching/display logic pops them. It sits between the input-data `fifo` and the sub-block consumer in the top-level `skeleton`.

---
 rtl/conv_encoder_bs_pkg.sv | 44 ++++
 rtl/fifo.sv | 52 +++++
 rtl/conv_encoder_bs.sv | 105 ++++++++++
 tb/tb_conv_encoder_bs.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_encoder_bs_pkg.sv
// Shared constants, FSM encoding and the byte-wide encoder function for conv_encoder_bs.
// The LTE rate-1/3 K=7 code generators are stored as 7-bit masks, with the MSB on u(k).
package conv_encoder_bs_pkg;

    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;
    localparam logic [6:0] G2 = 7'o165;

    localparam logic [9:0] BYTES_SHORT = 10'd132;
    localparam logic [9:0] BYTES_LONG  = 10'd768;

    // Stop requesting here: one write may be landing and one more may be in flight.
    localparam logic [9:0] FIFO_HIGH_WATER = 10'd1022;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENCODE
    } state_t;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
    } parity_t;

    // s[0] = u(k-1) ... s[5] = u(k-6); b[7] is the earliest bit of the byte.
    function automatic parity_t encode_byte(input logic [5:0] s, input logic [7:0] b);
        parity_t    p;
        logic [5:0] st;
        logic [6:0] w;
        p  = '0;
        st = s;
        for (int i = 7; i >= 0; i--) begin
            w        = {b[i], st[0], st[1], st[2], st[3], st[4], st[5]};
            p.d0[i]  = ^(w & G0);
            p.d1[i]  = ^(w & G1);
            p.d2[i]  = ^(w & G2);
            st       = {st[4:0], b[i]};
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo.sv
// 1024 x 8 show-ahead byte FIFO; q shows the head entry (0x00 when empty).
// Writes while full and reads while empty are dropped; push and pop may coincide.
module fifo (
    input  logic       clock,
    input  logic [7:0] data,
    input  logic       rdreq,
    input  logic       aclr,
    input  logic       wrreq,
    output logic       empty,
    output logic [7:0] q,
    output logic [9:0] usedw
);

    localparam int DEPTH = 1024;

    logic [7:0]  mem [DEPTH];
    logic [9:0]  wr_ptr;
    logic [9:0]  rd_ptr;
    logic [10:0] count;
    logic        do_wr;
    logic        do_rd;

    assign do_rd = rdreq && (count != 11'd0);
    assign do_wr = wrreq && (count != 11'(DEPTH));

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 10'd1;
            if (do_rd) rd_ptr <= rd_ptr + 10'd1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 11'd1;
                2'b01:   count <= count - 11'd1;
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == 11'd0);
    assign usedw = count[9:0];
    assign q     = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/conv_encoder_bs.sv
// Byte-serial tail-biting rate-1/3 convolutional encoder feeding three output byte FIFOs.
// One byte per cycle, 1 cycle request-to-FIFO; stalls on upstream empty or output high-water.
module conv_encoder_bs
    import conv_encoder_bs_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] tail_byte,
    input  logic       code_block_length,
    input  logic       blk_empty,
    input  logic [7:0] blk_data,
    output logic       blk_data_rdreq,
    output logic [7:0] q0,
    output logic [7:0] q1,
    output logic [7:0] q2,
    input  logic       rdreq_subblock,
    output logic       computation_done,
    output logic       length_out,
    output logic       empty
);

    state_t     state, state_nxt;
    logic [5:0] enc_state;
    logic [9:0] req_cnt;
    logic [9:0] wr_cnt;
    logic       pending;
    logic       done_q;
    logic       len_q;
    logic [9:0] n_bytes;
    logic       room;
    logic       last_wr;
    parity_t    par;
    logic [9:0] usedw0, usedw1, usedw2;
    logic       empty0, empty1, empty2;
    logic       aclr;

    assign aclr    = ~reset;
    assign n_bytes = len_q ? BYTES_LONG : BYTES_SHORT;
    assign room    = (usedw0 < FIFO_HIGH_WATER) && (usedw1 < FIFO_HIGH_WATER) &&
                     (usedw2 < FIFO_HIGH_WATER);

    assign blk_data_rdreq = (state == ST_ENCODE) && !blk_empty && room && (req_cnt < n_bytes);
    assign last_wr        = pending && (wr_cnt == n_bytes - 10'd1);
    assign par            = encode_byte(enc_state, blk_data);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (data_valid) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_ENCODE;
            ST_ENCODE: if (last_wr) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            enc_state <= '0;
            req_cnt   <= '0;
            wr_cnt    <= '0;
            pending   <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= blk_data_rdreq;
            done_q  <= last_wr;
            if (state == ST_IDLE && data_valid) begin
                enc_state <= tail_byte[5:0];
                len_q     <= code_block_length;
                req_cnt   <= '0;
                wr_cnt    <= '0;
            end else begin
                if (blk_data_rdreq) req_cnt <= req_cnt + 10'd1;
                // The returned byte's last six bits become u(k-1)..u(k-6) for the next byte.
                if (pending) begin
                    enc_state <= blk_data[5:0];
                    wr_cnt    <= wr_cnt + 10'd1;
                end
            end
        end
    end

    fifo u_fifo0 (
        .clock(clk), .data(par.d0), .rdreq(rdreq_subblock), .aclr(aclr),
        .wrreq(pending), .empty(empty0), .q(q0), .usedw(usedw0)
    );

    fifo u_fifo1 (
        .clock(clk), .data(par.d1), .rdreq(rdreq_subblock), .aclr(aclr),
        .wrreq(pending), .empty(empty1), .q(q1), .usedw(usedw1)
    );

    fifo u_fifo2 (
        .clock(clk), .data(par.d2), .rdreq(rdreq_subblock), .aclr(aclr),
        .wrreq(pending), .empty(empty2), .q(q2), .usedw(usedw2)
    );

    assign empty            = empty0 & empty1 & empty2;
    assign computation_done = done_q;
    assign length_out       = len_q;

endmodule

// File: tb/tb_conv_encoder_bs.sv
// Scoreboard bench for conv_encoder_bs: upstream byte source, bit-level reference encoder, drain checker.
module tb_conv_encoder_bs;
    import conv_encoder_bs_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] tail_byte;
    logic       code_block_length;
    logic       blk_empty;
    logic [7:0] blk_data;
    logic       blk_data_rdreq;
    logic [7:0] q0, q1, q2;
    logic       rdreq_subblock;
    logic       computation_done;
    logic       length_out;
    logic       empty;

    int errors = 0;
    int checks = 0;

    logic [7:0] up_q[$];
    logic [7:0] blk_buf[$];
    logic [7:0] exp0[$], exp1[$], exp2[$];
    int         pops = 0;
    int         stall_at = -1;
    int         stall_left = 0;
    int         base_cyc = 0;

    conv_encoder_bs dut (
        .clk(clk), .reset(reset), .data_valid(data_valid), .tail_byte(tail_byte),
        .code_block_length(code_block_length), .blk_empty(blk_empty), .blk_data(blk_data),
        .blk_data_rdreq(blk_data_rdreq), .q0(q0), .q1(q1), .q2(q2),
        .rdreq_subblock(rdreq_subblock), .computation_done(computation_done),
        .length_out(length_out), .empty(empty)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: read data appears one cycle after the request.
    initial begin
        logic r;
        forever begin
            @(negedge clk);
            r = blk_data_rdreq;
            @(posedge clk);
            #1;
            if (r === 1'b1) begin
                if (up_q.size() > 0) blk_data = up_q.pop_front();
                pops++;
            end
            if (stall_left > 0 && pops == stall_at) begin
                blk_empty = 1'b1;
                stall_left--;
            end else begin
                blk_empty = (up_q.size() == 0);
            end
        end
    end

    // Reference encoder written directly from the tap equations.
    task automatic model_block(input logic [7:0] tail);
        logic [6:0] m;
        logic [7:0] b, e0, e1, e2;
        logic       u;
        for (int j = 1; j <= 6; j++) m[j] = tail[j-1];
        m[0] = 1'b0;
        foreach (blk_buf[k]) begin
            b = blk_buf[k];
            for (int i = 7; i >= 0; i--) begin
                u     = b[i];
                e0[i] = u ^ m[2] ^ m[3] ^ m[5] ^ m[6];
                e1[i] = u ^ m[1] ^ m[2] ^ m[3] ^ m[6];
                e2[i] = u ^ m[1] ^ m[2] ^ m[4] ^ m[6];
                for (int j = 6; j >= 2; j--) m[j] = m[j-1];
                m[1] = u;
            end
            exp0.push_back(e0);
            exp1.push_back(e1);
            exp2.push_back(e2);
        end
    endtask

    task automatic start_block(input logic [7:0] tail, input logic len);
        pops = 0;
        foreach (blk_buf[k]) up_q.push_back(blk_buf[k]);
        model_block(tail);
        @(posedge clk);
        #1;
        tail_byte         = tail;
        code_block_length = len;
        data_valid        = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int cyc);
        int  n;
        int  extra;
        bit  dn;
        n   = blk_buf.size();
        cyc = 0;
        dn  = 0;
        while (cyc < n + 200) begin
            @(negedge clk);
            if (computation_done === 1'b1) begin
                dn = 1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        checks++;
        if (!dn) begin
            errors++;
            $display("FAIL %s done_timeout: no computation_done within %0d cycles", nm, cyc);
        end
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (computation_done !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d extra high cycles, expected 0", nm, extra);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (empty === 1'b1) break;
            checks++;
            if (exp0.size() == 0) begin
                errors++;
                $display("FAIL %s extra_byte: DUT holds byte %0d, expected none", nm, n);
            end else begin
                logic [7:0] e0, e1, e2;
                e0 = exp0.pop_front();
                e1 = exp1.pop_front();
                e2 = exp2.pop_front();
                if ({q0, q1, q2} !== {e0, e1, e2}) begin
                    errors++;
                    $display("FAIL %s byte %0d: got q0=%h q1=%h q2=%h, expected %h %h %h",
                             nm, n, q0, q1, q2, e0, e1, e2);
                end
            end
            rdreq_subblock = 1'b1;
            @(posedge clk);
            #1;
            rdreq_subblock = 1'b0;
            n++;
        end
        checks++;
        if (exp0.size() != 0) begin
            errors++;
            $display("FAIL %s missing_bytes: got %0d bytes, %0d still expected", nm, n, exp0.size());
        end
        exp0.delete();
        exp1.delete();
        exp2.delete();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL %s empty_after: got %b expected 1", nm, empty);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; data_valid = 1'b0; tail_byte = '0; code_block_length = 1'b0;
        blk_empty = 1'b1; blk_data = '0; rdreq_subblock = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({blk_data_rdreq, computation_done, length_out, empty} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl: got rdreq=%b done=%b len=%b empty=%b, expected 0 0 0 1",
                     blk_data_rdreq, computation_done, length_out, empty);
        end
        checks++;
        if ({q0, q1, q2} !== 24'h0) begin
            errors++;
            $display("FAIL reset_q: got %h %h %h expected 00 00 00", q0, q1, q2);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_pop_empty;
        @(negedge clk);
        rdreq_subblock = 1'b1;
        @(posedge clk);
        #1 rdreq_subblock = 1'b0;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || q0 !== 8'h00) begin
            errors++;
            $display("FAIL pop_empty: got empty=%b q0=%h expected 1 00", empty, q0);
        end
    endtask

    task automatic fill_buf(input int n, input int mode);
        blk_buf.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 0)      blk_buf.push_back(8'h00);
            else if (mode == 1) blk_buf.push_back(i == 0 ? 8'h80 : 8'h00);
            else                blk_buf.push_back(8'($urandom));
        end
    endtask

    task automatic check_head(input string nm, input logic [23:0] want);
        @(negedge clk);
        checks++;
        if ({q0, q1, q2} !== want) begin
            errors++;
            $display("FAIL %s head: got %h %h %h expected %h", nm, q0, q1, q2, want);
        end
    endtask

    task automatic test_all_zero;
        int cyc;
        fill_buf(132, 0);
        start_block(8'h00, 1'b0);
        wait_done("all_zero", cyc);
        base_cyc = cyc;
        checks++;
        if (cyc < 133 || cyc > 135) begin
            errors++;
            $display("FAIL all_zero latency: got %0d cycles after E0, expected 133..135", cyc);
        end
        checks++;
        if (length_out !== 1'b0) begin
            errors++;
            $display("FAIL all_zero length_out: got %b expected 0", length_out);
        end
        drain("all_zero");
    endtask

    task automatic test_impulse;
        int cyc;
        fill_buf(132, 1);
        start_block(8'h00, 1'b0);
        wait_done("impulse", cyc);
        check_head("impulse", 24'hB6F2EA);
        drain("impulse");
    endtask

    task automatic test_seed;
        int cyc;
        fill_buf(132, 0);
        start_block(8'h01, 1'b0);
        wait_done("seed", cyc);
        check_head("seed", 24'h6CE4D4);
        drain("seed");
    endtask

    task automatic test_long;
        int cyc;
        fill_buf(768, 2);
        start_block(8'hC7, 1'b1);
        wait_done("long", cyc);
        checks++;
        if (length_out !== 1'b1) begin
            errors++;
            $display("FAIL long length_out: got %b expected 1", length_out);
        end
        drain("long");
    endtask

    task automatic test_stall;
        int cyc;
        fill_buf(132, 2);
        stall_at   = 50;
        stall_left = 10;
        start_block(8'h3B, 1'b0);
        wait_done("stall", cyc);
        checks++;
        if (cyc != base_cyc + 10) begin
            errors++;
            $display("FAIL stall latency: got %0d expected %0d", cyc, base_cyc + 10);
        end
        stall_at = -1;
        drain("stall");
    endtask

    task automatic test_reset_mid;
        int cyc;
        int seen;
        fill_buf(132, 2);
        start_block(8'h15, 1'b0);
        repeat (40) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        up_q.delete();
        exp0.delete();
        exp1.delete();
        exp2.delete();
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || blk_data_rdreq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: got empty=%b rdreq=%b expected 1 0", empty, blk_data_rdreq);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid state: got %0d expected IDLE", dut.state);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (computation_done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid quiet: got done_cycles=%0d empty=%b expected 0 1", seen, empty);
        end
        fill_buf(132, 2);
        start_block(8'hA4, 1'b0);
        wait_done("after_reset", cyc);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_pop_empty();
        test_all_zero();
        test_impulse();
        test_seed();
        test_long();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
